// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port req/ack arbiter sharing one combinational-read RAM.
//            Port 0 is the CPU data port and port 1 is the loader/debug port.
//            Each grant runs one RAM access: IDLE -> ACCESS -> DONE.
//            Read data is registered and returned with a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic          CLK,
    input  logic          RST,
    // port 0 (CPU data)
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    // port 1 (loader / debug)
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    // shared RAM
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    // status
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          last_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          elig0_d;
    logic          elig1_d;
    logic          grant_d;
    logic          winner_d;
    logic          win_we_d;
    logic [AW-1:0] win_addr_d;
    logic [DW-1:0] win_wdata_d;
    logic [DW-1:0] capture_d;

    // Arbitration: mask the port being acked in DONE, then pick the winner
    always_comb begin
        elig0_d = req0 && !(state_q == ST_DONE && !owner_q);
        elig1_d = req1 && !(state_q == ST_DONE &&  owner_q);
        grant_d = (state_q != ST_ACCESS) && (elig0_d || elig1_d);
        if (elig0_d && elig1_d) begin
            winner_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            winner_d = elig1_d;
        end
        win_we_d    = winner_d ? we1    : we0;
        win_addr_d  = winner_d ? addr1  : addr0;
        win_wdata_d = winner_d ? wdata1 : wdata0;
        // A write returns the value it stores, which is what the RAM shows
        // combinationally once the write has committed.
        capture_d   = ram_we_q ? ram_wdata_q : ram_rdata;
    end

    // Access sequencer: grant, drive the RAM for one cycle, ack for one cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state_q)
                ST_ACCESS: begin
                    ram_we_q    <= 1'b0;
                    ram_addr_q  <= '0;
                    ram_wdata_q <= '0;
                    if (owner_q) begin
                        rdata1_q <= capture_d;
                        ack1_q   <= 1'b1;
                    end else begin
                        rdata0_q <= capture_d;
                        ack0_q   <= 1'b1;
                    end
                    state_q <= ST_DONE;
                end
                ST_IDLE, ST_DONE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (grant_d) begin
                        owner_q     <= winner_d;
                        last_q      <= winner_d;
                        ram_we_q    <= win_we_d;
                        ram_addr_q  <= win_addr_d;
                        ram_wdata_q <= win_wdata_d;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACCESS;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ack0_q      <= 1'b0;
                    ack1_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    ram_we_q    <= 1'b0;
                    ram_addr_q  <= '0;
                    ram_wdata_q <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule
`default_nettype wire
